stereo_disparity_scan: RTL and testbench
========================================

Name: stereo_disparity_scan

Overview:
- Sits downstream of the two camera frame-buffer RAMs, as a second read client alongside the VGA viewer.
- On request, copies one image row from the left RAM and the same row from the right RAM into internal line buffers.
- Runs a 1-D sum-of-absolute-differences (SAD) block match along that row.
- Emits the best disparity per column; the distance-estimation stage consumes this stream.

Parameters:
- IMG_W, 160: pixels per row; frame address = row*IMG_W + col.
- IMG_H, 120: rows per frame.
- MAX_DISP, 32: number of disparity candidates, 0..MAX_DISP-1; must be ≤64.
- WIN, 4: match window width in pixels; must be ≤32.
- SAD_MAX, 12: rejection threshold, used only with SAD_THRESH_EN.

Ports:
- sysclk  in  1  system clock; the frame RAM read ports are also clocked by it.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to scan a row.
- row  in  8  row to scan; sampled when start is accepted.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at the end of a scan.
- rdaddrl  out  16  left RAM read address.
- rdenl  out  1  left RAM read enable.
- datal  in  3  left RAM read data, valid 1 cycle after the address.
- rdaddrr  out  16  right RAM read address.
- rdenr  out  1  right RAM read enable.
- datar  in  3  right RAM read data, valid 1 cycle after the address.
- disp_valid  out  1  disp_x/disp/disp_sad/disp_ok are valid this cycle.
- disp_x  out  8  column of the result.
- disp  out  6  best disparity.
- disp_sad  out  8  SAD of the best disparity.
- disp_ok  out  1  result passed the confidence check.

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0, FSM returns to IDLE. This applies at any point, including mid-LOAD or mid-SCAN; the partial scan is discarded and no done is issued.
- FSM states: IDLE -> LOAD -> SCAN -> FIN -> IDLE.
- IDLE:
  - start=1 with row<IMG_H: latch row, go to LOAD; busy=1 from the next cycle.
  - start with row≥IMG_H: ignored, no busy and no done.
  - start while busy: ignored.
- LOAD:
  - Cycles c=0..IMG_W-1: rdenl=rdenr=1 and rdaddrl=rdaddrr=row*IMG_W+c. Address arithmetic is 16-bit, truncated.
  - Data from each read is written to lbufL[c] / lbufR[c] one cycle later.
  - LOAD lasts IMG_W+1 cycles. Read enables are 0 on the final cycle and in every other state.
- SCAN, column loop: for x = MAX_DISP .. IMG_W-WIN (inclusive).
- SCAN, disparity loop: for each x, d = 0..MAX_DISP-1, one d per cycle.
  - sad(d) = Σ_{k=0..WIN-1} |lbufL[x+k] - lbufR[x+k-d]|, computed as unsigned 3-bit differences summed at 8-bit width (no overflow for WIN≤32).
  - d=0 loads best; afterwards best is updated only if sad < best_sad (strictly less), so ties keep the smallest d.
- Per-column result:
  - On the cycle after the d=MAX_DISP-1 evaluation: disp_valid=1 for exactly one cycle, with disp_x=x, disp=best d, disp_sad=best sad.
  - The next column's d=0 evaluation overlaps that cycle, so each column costs MAX_DISP cycles.
- Result outputs hold their last value when disp_valid=0.
- FIN: entered after the last column's result; done=1 for one cycle, busy=0 in that same cycle, then IDLE. done always follows the final disp_valid by exactly one cycle.
- Result count per scan: IMG_W-WIN-MAX_DISP+1 (125 with defaults).
- busy stays 1 from the cycle after start acceptance through the last disp_valid cycle.

Optional Feature:
- Macro: SAD_THRESH_EN.
- Defined: disp_ok = (best_sad ≤ SAD_MAX). When disp_ok=0, disp is forced to 0 and disp_sad still reports the true best SAD.
- Undefined: disp_ok=1 whenever disp_valid=1; SAD_MAX unused.
- disp_ok is 0 in reset either way.

Test Plan:
- Shifted feature:
  - Stimulus: both rows 0 except right[60..63]=7 and left[70..73]=7; start, row=5.
  - Required: reads cover addresses 800..959; at disp_x=70, disp=10 and disp_sad=0; columns whose window is all zero give disp=0, sad=0; 125 disp_valid pulses; done one cycle after the last.
- Address wrap / row bounds:
  - row=119: last read address is 19199.
  - row=120: no busy, no reads, no done.
- Tie-break: both rows uniform 3 -> every column disp=0, sad=0.
- Start during busy: second start at cycle 50 of LOAD is ignored; exactly one done and 125 results.
- Async reset: resetn low mid-SCAN -> all outputs 0 immediately, no done; a new start afterwards completes normally.
- SAD_THRESH_EN defined:
  - Stimulus: left row all 7, right row all 0.
  - Required: every result has disp_sad=28, disp_ok=0, disp=0.
  - With the macro undefined: disp_ok=1 and disp=0 (tie rule).

Source files
------------

// File: rtl/stereo_disparity_scan.sv
// stereo_disparity_scan
//   Second read client on the left/right camera frame-buffer RAMs. On a start
//   request it copies one row from each RAM into internal line buffers, then
//   runs a 1-D sum-of-absolute-differences block match along the row and
//   streams out the best disparity for every column that has a full window
//   and a full disparity range available.
//
//   Optional feature macro: SAD_THRESH_EN
//     defined   : disp_ok = (best SAD <= SAD_MAX); rejected results report disp=0
//     undefined : disp_ok = 1 on every result, SAD_MAX unused
//
// Ports
//   sysclk, resetn          clock / asynchronous active-low reset
//   start, row              scan request (row sampled on acceptance)
//   busy, done              scan in progress / one-cycle end-of-scan pulse
//   rdaddrl, rdenl, datal   left RAM read port (data one cycle after address)
//   rdaddrr, rdenr, datar   right RAM read port
//   disp_valid              result strobe for disp_x/disp/disp_sad/disp_ok
//   disp_x, disp, disp_sad  column, best disparity, SAD of best disparity
//   disp_ok                 confidence flag
module stereo_disparity_scan #(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int MAX_DISP = 32,
    parameter int WIN      = 4,
    parameter int SAD_MAX  = 12
) (
    input  logic        sysclk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  row,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdaddrl,
    output logic        rdenl,
    input  logic [2:0]  datal,
    output logic [15:0] rdaddrr,
    output logic        rdenr,
    input  logic [2:0]  datar,
    output logic        disp_valid,
    output logic [7:0]  disp_x,
    output logic [5:0]  disp,
    output logic [7:0]  disp_sad,
    output logic        disp_ok
);

    localparam int CW      = $clog2(IMG_W + 1);  // load counter / column width
    localparam int IW      = $clog2(IMG_W);      // line buffer index width
    localparam int X_FIRST = MAX_DISP;
    localparam int X_LAST  = IMG_W - WIN;

    // Elaboration guard: 6-bit disparity and 8-bit SAD accumulation limits.
    if (MAX_DISP > 64 || MAX_DISP < 1 || WIN > 32 || WIN < 1 ||
        SAD_MAX < 0 || SAD_MAX > 255 || X_FIRST > X_LAST) begin : g_cfg_err
        $error("stereo_disparity_scan: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_FIN} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [5:0] d;
        logic [7:0] sad;
        logic       ok;
    } res_t;

    state_t        state, state_nxt;
    logic [7:0]    row_q;
    logic [CW-1:0] cnt;         // LOAD cycle index 0..IMG_W
    logic [CW-1:0] x_q;         // current column
    logic [5:0]    d_q;         // current disparity candidate
    logic [5:0]    best_d;
    logic [7:0]    best_sad;
    logic          last_q;      // last column evaluated; draining its result
    res_t          res_q;
    logic          res_vld;

    logic [2:0]    lbuf_l [IMG_W];
    logic [2:0]    lbuf_r [IMG_W];

    logic          accept;
    logic          col_end;
    logic          last_eval;
    logic [7:0]    sad;
    logic [5:0]    fin_d;
    logic [7:0]    fin_sad;
    logic          fin_ok;
    logic          rden;
    logic [15:0]   rdaddr;

    function automatic logic [2:0] absdiff3(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    assign accept    = (state == S_IDLE) && start && (32'(row) < IMG_H);
    // last_q blocks a spurious column end in the drain cycle (matters when MAX_DISP==1)
    assign col_end   = (state == S_SCAN) && !last_q && (d_q == 6'(MAX_DISP - 1));
    assign last_eval = col_end && (x_q == CW'(X_LAST));

    // SAD for the current (x, d) pair straight out of the line buffers.
    // x >= MAX_DISP > d, so the right-buffer index never goes negative.
    always_comb begin
        sad = '0;
        for (int k = 0; k < WIN; k++) begin
            sad = sad + 8'(absdiff3(lbuf_l[IW'(32'(x_q) + 32'(k))],
                                    lbuf_r[IW'(32'(x_q) + 32'(k) - 32'(d_q))]));
        end
    end

    // Running best including this cycle's candidate; d=0 always reloads.
    // Strict '<' keeps the smallest d on ties.
    always_comb begin
        fin_d   = best_d;
        fin_sad = best_sad;
        if (d_q == '0 || sad < best_sad) begin
            fin_d   = d_q;
            fin_sad = sad;
        end
`ifdef SAD_THRESH_EN
        fin_ok = (fin_sad <= 8'(SAD_MAX));
`else
        fin_ok = 1'b1;
`endif
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)               state_nxt = S_LOAD;
            S_LOAD: if (cnt == CW'(IMG_W))    state_nxt = S_SCAN;
            S_SCAN: if (last_q)               state_nxt = S_FIN;
            S_FIN:                            state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state == S_LOAD) || (state == S_SCAN);
        done   = (state == S_FIN);
        rden   = (state == S_LOAD) && (cnt < CW'(IMG_W));
        rdaddr = '0;
        if (rden) rdaddr = 16'(row_q) * 16'(IMG_W) + 16'(cnt);
    end

    assign rdenl   = rden;
    assign rdenr   = rden;
    assign rdaddrl = rdaddr;
    assign rdaddrr = rdaddr;

    // ---------------- datapath control ----------------
    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            row_q    <= '0;
            cnt      <= '0;
            x_q      <= '0;
            d_q      <= '0;
            best_d   <= '0;
            best_sad <= '0;
            last_q   <= 1'b0;
            res_q    <= '0;
            res_vld  <= 1'b0;
        end else begin
            res_vld <= col_end;
            last_q  <= last_eval;
            if (col_end) begin
                res_q.x   <= 8'(x_q);
                res_q.d   <= fin_ok ? fin_d : 6'd0;
                res_q.sad <= fin_sad;
                res_q.ok  <= fin_ok;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        row_q <= row;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(IMG_W)) begin
                        x_q <= CW'(X_FIRST);
                        d_q <= '0;
                    end
                end
                S_SCAN: begin
                    best_d   <= fin_d;
                    best_sad <= fin_sad;
                    if (col_end) begin
                        d_q <= '0;
                        if (!last_eval) x_q <= x_q + 1'b1;
                    end else if (!last_q) begin
                        d_q <= d_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer fill: RAM data for address c lands while cnt == c+1.
    always_ff @(posedge sysclk) begin
        if (state == S_LOAD && cnt != '0) begin
            lbuf_l[IW'(cnt - 1'b1)] <= datal;
            lbuf_r[IW'(cnt - 1'b1)] <= datar;
        end
    end

    assign disp_valid = res_vld;
    assign disp_x     = res_q.x;
    assign disp       = res_q.d;
    assign disp_sad   = res_q.sad;
    assign disp_ok    = res_q.ok;

endmodule

// File: tb/tb_stereo_disparity_scan.sv
// Scoreboard bench for stereo_disparity_scan: stimulus pushes expected
// per-column results into a queue; a negedge monitor pops and compares on
// every disp_valid and tracks reads, busy and done.
module tb_stereo_disparity_scan;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int MAX_DISP = 32;
    localparam int WIN = 4;
    localparam int NRES = IMG_W - WIN - MAX_DISP + 1;
    localparam int MEM = IMG_W * IMG_H;

    logic        sysclk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  row = '0;
    logic        busy, done, rdenl, rdenr, disp_valid, disp_ok;
    logic [15:0] rdaddrl, rdaddrr;
    logic [2:0]  datal = '0, datar = '0;
    logic [7:0]  disp_x, disp_sad;
    logic [5:0]  disp;

    stereo_disparity_scan dut (
        .sysclk(sysclk), .resetn(resetn), .start(start), .row(row),
        .busy(busy), .done(done),
        .rdaddrl(rdaddrl), .rdenl(rdenl), .datal(datal),
        .rdaddrr(rdaddrr), .rdenr(rdenr), .datar(datar),
        .disp_valid(disp_valid), .disp_x(disp_x), .disp(disp),
        .disp_sad(disp_sad), .disp_ok(disp_ok)
    );

    always #5 sysclk = ~sysclk;

    // frame RAMs, one-cycle read latency
    logic [2:0] ram_l [MEM];
    logic [2:0] ram_r [MEM];
    always @(posedge sysclk) begin
        if (rdenl && int'(rdaddrl) < MEM) datal <= ram_l[rdaddrl];
        if (rdenr && int'(rdaddrr) < MEM) datar <= ram_r[rdaddrr];
    end

    typedef struct { int x; int d; int sad; int ok; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int res_cnt, done_cnt, busy_cnt, rd_cnt, first_addr, last_addr;
    int cap70_d, cap70_sad, cap70_ok, cap40_d, cap40_sad;
    bit prev_valid = 1'b0;
    int tb_l [IMG_W];
    int tb_r [IMG_W];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge sysclk) begin
        if (resetn) begin
            if (busy) busy_cnt++;
            if (rdenl || rdenr) begin
                check("rd_left_right_match", int'({rdenl, rdaddrl}), int'({rdenr, rdaddrr}));
                if (rd_cnt == 0) first_addr = int'(rdaddrl);
                last_addr = int'(rdaddrl);
                rd_cnt++;
            end
            if (disp_valid) begin
                res_cnt++;
                check("busy_during_valid", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    check("exp_queue_nonempty", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("disp_x", int'(disp_x), e.x);
                    check("disp", int'(disp), e.d);
                    check("disp_sad", int'(disp_sad), e.sad);
                    check("disp_ok", int'(disp_ok), e.ok);
                end
                if (disp_x == 8'd70) begin
                    cap70_d = int'(disp); cap70_sad = int'(disp_sad); cap70_ok = int'(disp_ok);
                end
                if (disp_x == 8'd40) begin
                    cap40_d = int'(disp); cap40_sad = int'(disp_sad);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_valid", int'(prev_valid), 1);
                check("busy_low_at_done", int'(busy), 0);
            end
            prev_valid = disp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic write_row(input int r);
        for (int c = 0; c < IMG_W; c++) begin
            ram_l[r*IMG_W + c] = 3'(tb_l[c]);
            ram_r[r*IMG_W + c] = 3'(tb_r[c]);
        end
    endtask

    task automatic fill(input int lv, input int rv);
        for (int c = 0; c < IMG_W; c++) begin
            tb_l[c] = lv;
            tb_r[c] = rv;
        end
    endtask

    // reference: exhaustive SAD search straight from the definition
    task automatic push_model();
        for (int x = MAX_DISP; x <= IMG_W - WIN; x++) begin
            exp_t e;
            int best, bd, s, df;
            best = 0; bd = 0;
            for (int d = 0; d < MAX_DISP; d++) begin
                s = 0;
                for (int k = 0; k < WIN; k++) begin
                    df = tb_l[x+k] - tb_r[x+k-d];
                    s += (df < 0) ? -df : df;
                end
                if (d == 0 || s < best) begin best = s; bd = d; end
            end
            e.x = x; e.sad = best; e.d = bd; e.ok = 1;
`ifdef SAD_THRESH_EN
            if (best > 12) begin e.ok = 0; e.d = 0; end
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        res_cnt = 0; done_cnt = 0; busy_cnt = 0; rd_cnt = 0;
        first_addr = -1; last_addr = -1;
        cap70_d = -1; cap70_sad = -1; cap70_ok = -1; cap40_d = -1; cap40_sad = -1;
    endtask

    task automatic pulse_start(input int r);
        @(posedge sysclk); #1;
        start = 1'b1; row = 8'(r);
        @(posedge sysclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge sysclk);
            n++;
        end
        if (done_cnt == 0) check("done_timeout", done_cnt, 1);
        repeat (6) @(posedge sysclk);
    endtask

    task automatic run_scan(input int r, input int faddr, input int laddr, input int extra_at);
        clear_stats();
        push_model();
        pulse_start(r);
        if (extra_at > 0) begin
            repeat (extra_at - 1) @(posedge sysclk);
            pulse_start(r + 2);
        end
        wait_done(6000);
        check("result_count", res_cnt, NRES);
        check("done_count", done_cnt, 1);
        check("queue_drained", exp_q.size(), 0);
        check("read_count", rd_cnt, IMG_W);
        check("first_read_addr", first_addr, faddr);
        check("last_read_addr", last_addr, laddr);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_rden"}, int'({rdenl, rdenr}), 0);
        check({tag, "_rdaddr"}, int'({rdaddrl, rdaddrr}), 0);
        check({tag, "_disp_valid"}, int'(disp_valid), 0);
        check({tag, "_disp_x"}, int'(disp_x), 0);
        check({tag, "_disp"}, int'(disp), 0);
        check({tag, "_disp_sad"}, int'(disp_sad), 0);
        check({tag, "_disp_ok"}, int'(disp_ok), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int i = 0; i < MEM; i++) begin ram_l[i] = '0; ram_r[i] = '0; end
        clear_stats();
        #12;
        check_outputs_zero("reset");
        @(negedge sysclk); resetn = 1'b1;
        repeat (3) @(posedge sysclk);

        // shifted feature: left 70..73 = right 60..63 -> disparity 10
        fill(0, 0);
        for (int c = 70; c < 74; c++) tb_l[c] = 7;
        for (int c = 60; c < 64; c++) tb_r[c] = 7;
        write_row(5);
        run_scan(5, 800, 959, -1);
        check("feature_x70_disp", cap70_d, 10);
        check("feature_x70_sad", cap70_sad, 0);
        check("flat_x40_disp", cap40_d, 0);
        check("flat_x40_sad", cap40_sad, 0);

        // last row + tie-break on a uniform image
        fill(3, 3);
        write_row(119);
        run_scan(119, 19040, 19199, -1);
        check("tie_x70_disp", cap70_d, 0);
        check("tie_x70_sad", cap70_sad, 0);

        // out-of-range row is ignored
        clear_stats();
        pulse_start(120);
        repeat (200) @(posedge sysclk);
        check("row120_busy_cycles", busy_cnt, 0);
        check("row120_reads", rd_cnt, 0);
        check("row120_done", done_cnt, 0);
        check("row120_results", res_cnt, 0);

        // left all 7, right all 0; second start mid-LOAD must be ignored
        fill(7, 0);
        write_row(7);
        run_scan(7, 1120, 1279, 50);
        check("bright_x70_sad", cap70_sad, 28);
        check("bright_x70_disp", cap70_d, 0);
`ifdef SAD_THRESH_EN
        check("bright_x70_ok", cap70_ok, 0);
`else
        check("bright_x70_ok", cap70_ok, 1);
`endif

        // asynchronous reset mid-SCAN, then a clean rerun
        clear_stats();
        push_model();
        pulse_start(7);
        n = 0;
        while (res_cnt < 10 && n < 3000) begin @(posedge sysclk); n++; end
        check("pre_reset_results", int'(res_cnt >= 10), 1);
        @(posedge sysclk); #3;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        repeat (3) @(posedge sysclk);
        @(negedge sysclk); resetn = 1'b1;
        repeat (20) @(posedge sysclk);
        check("no_done_after_reset", done_cnt, 0);
        check("idle_after_reset", int'(busy), 0);
        run_scan(7, 1120, 1279, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
